// File: rtl/ssram_rr_arbiter.sv
// ssram_rr_arbiter
//   Round-robin arbiter that shares one SSRAM controller between the CPU (0),
//   the VGA master (1) and a future DMA master (2). It supports locked bursts
//   with a hold limit, urgent requests that outrank normal ones, and an ack
//   timeout that frees a hung bus.
//
//   Ports:
//     clk_i      system clock
//     rst_n      synchronous reset, active low
//     req_i      per-master request (cyc&stb), held until acked
//     lock_i     owner keeps the bus after the current ack
//     urgent_i   request outranks all non-urgent requests
//     ack_i      ack from the SSRAM controller
//     gnt_o      one-hot registered grant
//     gnt_idx_o  binary index of the owner, valid while cyc_o = 1
//     cyc_o      shared cycle toward the controller
//     stb_o      shared strobe = cyc_o & owner request
//     ack_o      ack_i routed to the owner only
//     err_o      one-cycle pulse to the owner on timeout
module ssram_rr_arbiter #(
  parameter int NMASTERS = 3,
  parameter int IDXW     = 2,
  parameter int MAXHOLD  = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [NMASTERS-1:0] req_i,
  input  logic [NMASTERS-1:0] lock_i,
  input  logic [NMASTERS-1:0] urgent_i,
  input  logic                ack_i,
  output logic [NMASTERS-1:0] gnt_o,
  output logic [IDXW-1:0]     gnt_idx_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic [NMASTERS-1:0] ack_o,
  output logic [NMASTERS-1:0] err_o
);

  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NMASTERS-1:0] ONE       = {{(NMASTERS-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]       HOLD_LAST = HW'(MAXHOLD - 1);
  localparam logic [TW-1:0]       TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0]     IDX_LAST  = IDXW'(NMASTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t              state_r;
  logic [IDXW-1:0]     ptr_r;
  logic [HW-1:0]       hold_cnt_r;
  logic [TW-1:0]       tmo_cnt_r;

  logic [NMASTERS-1:0] urgent_req_s;
  logic [NMASTERS-1:0] cand_s;
  logic                found_s;
  logic [IDXW-1:0]     winner_s;
  int                  idx_s;
  logic [NMASTERS-1:0] gnt_next_s;
  logic [IDXW-1:0]     ptr_next_s;
  logic                owner_req_s;
  logic                owner_lock_s;
  logic                others_wait_s;
  logic                urgent_wait_s;
  logic                cut_lock_s;

  // gnt_o is one-hot, so masking with it selects the owner's bits
  assign owner_req_s   = |(req_i & gnt_o);
  assign owner_lock_s  = |(lock_i & gnt_o);
  assign others_wait_s = |(req_i & ~gnt_o);
  assign urgent_wait_s = |(urgent_i & req_i & ~gnt_o);
  // A waiting urgent requester cuts the lock at the next ack, as does the hold limit
  assign cut_lock_s    = ((hold_cnt_r == HOLD_LAST) && others_wait_s) || urgent_wait_s;

  assign urgent_req_s  = urgent_i & req_i;
  assign cand_s        = (|urgent_req_s) ? urgent_req_s : req_i;

  assign stb_o = cyc_o & owner_req_s;
  // cyc_o is high only in GRANT, so non-owners and other states never see an ack
  assign ack_o = gnt_o & {NMASTERS{ack_i & cyc_o}};

  // Round-robin scan of the candidate set starting at the pointer
  always_comb begin
    found_s  = 1'b0;
    winner_s = {IDXW{1'b0}};
    idx_s    = 0;
    for (int i = 0; i < NMASTERS; i++) begin
      idx_s = int'(ptr_r) + i;
      idx_s = (idx_s >= NMASTERS) ? (idx_s - NMASTERS) : idx_s;
      if (!found_s && (|(cand_s & (ONE << idx_s)))) begin
        found_s  = 1'b1;
        winner_s = IDXW'(idx_s);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign gnt_next_s = ONE << winner_s;
  assign ptr_next_s = (winner_s == IDX_LAST) ? {IDXW{1'b0}} : (winner_s + IDXW'(1'b1));

  // Arbiter state machine with registered grant/cycle/error outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      ptr_r      <= {IDXW{1'b0}};
      hold_cnt_r <= {HW{1'b0}};
      tmo_cnt_r  <= {TW{1'b0}};
      gnt_o      <= {NMASTERS{1'b0}};
      gnt_idx_o  <= {IDXW{1'b0}};
      cyc_o      <= 1'b0;
      err_o      <= {NMASTERS{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          err_o <= {NMASTERS{1'b0}};
          if (found_s) begin
            state_r   <= S_GRANT;
            gnt_o     <= gnt_next_s;
            gnt_idx_o <= winner_s;
            cyc_o     <= 1'b1;
            ptr_r     <= ptr_next_s;
          end else begin
            state_r   <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (ack_i) begin
            tmo_cnt_r <= {TW{1'b0}};
            if (owner_lock_s && owner_req_s && !cut_lock_s) begin
              // Lock continues; the hold count saturates when nobody waits
              if (hold_cnt_r != HOLD_LAST) begin
                hold_cnt_r <= hold_cnt_r + HW'(1'b1);
              end else begin
                hold_cnt_r <= hold_cnt_r;
              end
            end else begin
              state_r    <= S_IDLE;
              gnt_o      <= {NMASTERS{1'b0}};
              gnt_idx_o  <= {IDXW{1'b0}};
              cyc_o      <= 1'b0;
              hold_cnt_r <= {HW{1'b0}};
            end
          end else if (!owner_req_s) begin
            // Owner withdrew its request: abort without an ack
            state_r    <= S_IDLE;
            gnt_o      <= {NMASTERS{1'b0}};
            gnt_idx_o  <= {IDXW{1'b0}};
            cyc_o      <= 1'b0;
            hold_cnt_r <= {HW{1'b0}};
            tmo_cnt_r  <= {TW{1'b0}};
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r    <= S_ERR;
            err_o      <= gnt_o;
            gnt_o      <= {NMASTERS{1'b0}};
            gnt_idx_o  <= {IDXW{1'b0}};
            cyc_o      <= 1'b0;
            hold_cnt_r <= {HW{1'b0}};
            tmo_cnt_r  <= {TW{1'b0}};
          end else begin
            tmo_cnt_r  <= tmo_cnt_r + TW'(1'b1);
          end
        end
        S_ERR: begin
          // ptr_r already points past the failed owner since its grant
          err_o   <= {NMASTERS{1'b0}};
          state_r <= S_IDLE;
        end
        default: begin
          state_r    <= S_IDLE;
          gnt_o      <= {NMASTERS{1'b0}};
          gnt_idx_o  <= {IDXW{1'b0}};
          cyc_o      <= 1'b0;
          err_o      <= {NMASTERS{1'b0}};
          hold_cnt_r <= {HW{1'b0}};
          tmo_cnt_r  <= {TW{1'b0}};
        end
      endcase
    end
  end

endmodule
